instr_fetch_unit: RTL and testbench

- Front end of the processor core. Fetches 32-bit instruction words from instruction memory and buffers them in a small FIFO.
- Presents one instruction at a time to the decode stage, already split into the op and funct fields the main decoder consumes.
- On a taken branch, redirects to the branch target and discards all stale instructions.

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front end. Issues one word fetch at a time to
// instruction memory, buffers responses in a DEPTH-entry FIFO and presents
// the head instruction (with its PC and op/funct fields) to decode.
// A taken branch redirects the PC, flushes the FIFO and discards any
// response still in flight.
// Optional halt detection: define IFU_HALT_DETECT_EN to stop fetching on
// HALT_WORD; otherwise HALT_WORD is an ordinary instruction.
module instr_fetch_unit #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic        halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

`ifdef IFU_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            halted_q, halted_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_pc_q    [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic rsp, halt_hit, push, pop;

  // Request/handshake decode; redirect suppresses issue, push and pop.
  always_comb begin
    imem_req = rst_n & (state_q == S_IDLE) & (count_q < DepthC)
             & ~branch_taken & ~halted_q;
    rsp      = (state_q == S_WAIT) & imem_rvalid;
    halt_hit = HaltEn & rsp & ~branch_taken & (imem_rdata == HALT_WORD);
    push     = rsp & ~branch_taken & ~halt_hit;
    pop      = instr_valid & instr_ready & ~branch_taken;
  end

  // FSM, PC and halt flag next state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    halted_d = halted_q;
    unique case (state_q)
      S_IDLE: if (imem_req) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)       state_d = S_IDLE;
        else if (branch_taken) state_d = S_DROP;
      end
      S_DROP: if (imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (imem_req) begin
      pc_d   = pc_q + 32'd4;
      addr_d = pc_q;
    end
    if (branch_taken) begin
      pc_d     = branch_target & ~32'd3;
      halted_d = 1'b0;
    end else if (halt_hit) begin
      halted_d = 1'b1;
    end
  end

  // FIFO pointer and occupancy next state; a redirect empties the FIFO.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch_taken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      halted_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= addr_q;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign op          = instr[27:26];
  assign funct       = instr[25:20];
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural memory with
// configurable latency, a passive log of accepted requests and pops, and
// per-scenario tasks comparing the logs against the fetch-stream model
// (sequential PCs, restart at the aligned target after a redirect).
module tb_instr_fetch_unit;
  logic        clk, rst_n;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        halted;

  int tests_run = 0;
  int failed    = 0;
  int cyc = 0, rel_cyc = 0, valid_edge = -1;
  int lat = 1;
  bit lat_rand = 0, late_inject = 0;
  int proto_err = 0;
  bit ovr_en = 0;
  logic [31:0] ovr_addr = '0, ovr_data = '0;

  typedef struct { logic [31:0] addr; int edge_n; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic [1:0] op; logic [5:0] funct; } pop_t;
  req_t rq[$];
  pop_t pq[$];

  instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .op(op), .funct(funct), .halted(halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Memory: answers each request after 'lat' edges, counts overlapping requests.
  initial begin : mem_model
    bit pending; int cnt; logic [31:0] paddr; bit was_rst;
    pending = 0; cnt = 0; paddr = '0; was_rst = 1;
    imem_rvalid = 0; imem_rdata = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        pending = 0; imem_rvalid = 0; was_rst = 1;
      end else begin
        imem_rvalid = 0;
        if (was_rst && late_inject) begin
          imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        end else if (pending) begin
          cnt--;
          if (cnt == 0) begin imem_rvalid = 1; imem_rdata = mem_word(paddr); pending = 0; end
        end
        was_rst = 0;
        if (imem_req) begin
          if (pending) proto_err++;
          pending = 1; paddr = imem_addr;
          cnt = lat_rand ? int'($urandom_range(1, 4)) : lat;
        end
      end
    end
  end

  // Passive log of accepted requests and pops, sampled just before each edge.
  initial begin : monitor
    req_t r; pop_t p;
    forever begin
      @(negedge clk); #3;
      if (rst_n) begin
        if (imem_req) begin r.addr = imem_addr; r.edge_n = cyc + 1; rq.push_back(r); end
        if (instr_valid && instr_ready && !branch_taken) begin
          p.pc = instr_pc; p.ins = instr; p.op = op; p.funct = funct; pq.push_back(p);
        end
        if (instr_valid && valid_edge < 0) valid_edge = cyc;
      end
    end
  end

  task automatic clear_logs();
    rq.delete(); pq.delete(); valid_edge = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; branch_taken = 0; branch_target = '0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1; rel_cyc = cyc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reset_req got %b want 0", imem_req); end
    tests_run++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    tests_run++; if (instr !== 32'h0) begin failed++; $display("FAIL reset_instr got %h want 0", instr); end
    tests_run++; if (instr_pc !== 32'h0) begin failed++; $display("FAIL reset_pc got %h want 0", instr_pc); end
    tests_run++; if (op !== 2'b00 || funct !== 6'b0) begin failed++; $display("FAIL reset_fields got %b/%b want 0/0", op, funct); end
    tests_run++; if (halted !== 1'b0) begin failed++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_stream();
    lat = 1; instr_ready = 1; do_reset();
    repeat (12) @(negedge clk);
    tests_run++; if (valid_edge != rel_cyc + 2) begin failed++; $display("FAIL stream_latency got %0d want %0d", valid_edge - rel_cyc, 2); end
    tests_run++; if (rq.size() < 4) begin failed++; $display("FAIL stream_reqs got %0d want >=4", rq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++; if (rq[i].addr !== 32'(4 * i)) begin failed++; $display("FAIL stream_addr%0d got %h want %h", i, rq[i].addr, 32'(4 * i)); end
      end
      tests_run++; if (rq[1].edge_n - rq[0].edge_n != 2) begin failed++; $display("FAIL stream_rate got %0d want 2", rq[1].edge_n - rq[0].edge_n); end
    end
    tests_run++; if (pq.size() < 4) begin failed++; $display("FAIL stream_pops got %0d want >=4", pq.size()); end
    for (int i = 0; i < pq.size(); i++) begin
      tests_run++;
      if (pq[i].pc !== 32'(4 * i) || pq[i].ins !== mem_word(32'(4 * i)) || pq[i].op !== pq[i].ins[27:26] || pq[i].funct !== pq[i].ins[25:20]) begin
        failed++; $display("FAIL stream_pop%0d got pc %h ins %h want pc %h ins %h", i, pq[i].pc, pq[i].ins, 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; instr_ready = 0; do_reset();
    repeat (10) @(negedge clk);
    tests_run++; if (rq.size() != 2) begin failed++; $display("FAIL bp_reqs got %0d want 2", rq.size()); end
    tests_run++; if (rq.size() >= 2 && (rq[0].addr !== 32'h0 || rq[1].addr !== 32'h4)) begin failed++; $display("FAIL bp_addrs got %h,%h want 0,4", rq[0].addr, rq[1].addr); end
    tests_run++; if (imem_req !== 1'b0) begin failed++; $display("FAIL bp_req_full got %b want 0", imem_req); end
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failed++; $display("FAIL bp_head got v%b pc %h want v1 pc 0", instr_valid, instr_pc); end
    instr_ready = 1;
    repeat (10) @(negedge clk);
    tests_run++; if (pq.size() < 3) begin failed++; $display("FAIL bp_drain got %0d want >=3", pq.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests_run++; if (pq[i].pc !== 32'(4 * i) || pq[i].ins !== mem_word(32'(4 * i))) begin failed++; $display("FAIL bp_pop%0d got pc %h want %h", i, pq[i].pc, 32'(4 * i)); end
    end
    tests_run++; if (rq.size() < 3 || rq[2].addr !== 32'h8) begin failed++; $display("FAIL bp_resume got n=%0d want addr 8", rq.size()); end
  endtask

  task automatic test_branch(input int l, input string nm);
    int br_edge, gap;
    lat = l; instr_ready = 1; do_reset();
    for (int i = 0; i < 20 && rq.size() < 1; i++) @(negedge clk);
    tests_run++; if (rq.size() < 1) begin failed++; $display("FAIL %s_timeout got 0 reqs want 1", nm); end
    branch_taken = 1; branch_target = 32'h0000_0103; br_edge = cyc + 1;
    @(negedge clk); branch_taken = 0;
    repeat (14) @(negedge clk);
    gap = (l == 1) ? 1 : l;
    tests_run++; if (rq.size() < 2) begin failed++; $display("FAIL %s_reqs got %0d want >=2", nm, rq.size()); end
    else begin
      tests_run++; if (rq[1].addr !== 32'h100) begin failed++; $display("FAIL %s_target got %h want 100", nm, rq[1].addr); end
      tests_run++; if (rq[1].edge_n != br_edge + gap) begin failed++; $display("FAIL %s_reissue got %0d want %0d", nm, rq[1].edge_n - br_edge, gap); end
      tests_run++; if (valid_edge != rq[1].edge_n + l) begin failed++; $display("FAIL %s_stale_valid got %0d want %0d", nm, valid_edge, rq[1].edge_n + l); end
    end
    tests_run++; if (pq.size() < 1 || pq[0].pc !== 32'h100 || pq[0].ins !== mem_word(32'h100)) begin failed++; $display("FAIL %s_first_pop got n=%0d want pc 100", nm, pq.size()); end
    tests_run++; if (proto_err != 0) begin failed++; $display("FAIL %s_outstanding got %0d want 0", nm, proto_err); end
  endtask

  task automatic test_fields();
    lat = 1; instr_ready = 0; ovr_en = 1; ovr_addr = 32'h0; ovr_data = 32'hE590_0004; do_reset();
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    tests_run++; if (instr !== 32'hE590_0004) begin failed++; $display("FAIL fields_instr got %h want e5900004", instr); end
    tests_run++; if (op !== 2'b01) begin failed++; $display("FAIL fields_op got %b want 01", op); end
    tests_run++; if (funct !== 6'b011001) begin failed++; $display("FAIL fields_funct got %b want 011001", funct); end
    tests_run++; if (instr_pc !== 32'h0) begin failed++; $display("FAIL fields_pc got %h want 0", instr_pc); end
    ovr_en = 0;
  endtask

  task automatic test_wrap();
    lat = 1; instr_ready = 1; do_reset();
    branch_taken = 1; branch_target = 32'hFFFF_FFFE;
    @(negedge clk); branch_taken = 0;
    repeat (10) @(negedge clk);
    tests_run++; if (rq.size() < 2 || rq[0].addr !== 32'hFFFF_FFFC || rq[1].addr !== 32'h0) begin failed++; $display("FAIL wrap_addr got n=%0d want fffffffc,0", rq.size()); end
    tests_run++; if (pq.size() < 2 || pq[0].pc !== 32'hFFFF_FFFC || pq[1].pc !== 32'h0 || pq[0].ins !== mem_word(32'hFFFF_FFFC)) begin failed++; $display("FAIL wrap_pops got n=%0d want pc fffffffc,0", pq.size()); end
  endtask

  task automatic test_reset_midwait();
    lat = 3; instr_ready = 0; do_reset();
    repeat (6) @(negedge clk);
    tests_run++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL midrst_pre got %b want 1", instr_valid); end
    #1 rst_n = 0;
    #1;
    tests_run++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin failed++; $display("FAIL midrst_ctl got %b%b%b want 000", imem_req, instr_valid, halted); end
    tests_run++; if (instr !== 32'h0 || instr_pc !== 32'h0 || op !== 2'b0 || funct !== 6'b0) begin failed++; $display("FAIL midrst_data got %h/%h want 0/0", instr, instr_pc); end
    @(negedge clk); @(negedge clk);
    clear_logs(); lat = 1; instr_ready = 1; late_inject = 1; rst_n = 1;
    @(negedge clk); late_inject = 0;
    repeat (8) @(negedge clk);
    tests_run++; if (rq.size() < 1 || rq[0].addr !== 32'h0) begin failed++; $display("FAIL midrst_restart got n=%0d want addr 0", rq.size()); end
    tests_run++; if (pq.size() < 1 || pq[0].pc !== 32'h0 || pq[0].ins !== mem_word(32'h0)) begin failed++; $display("FAIL midrst_late got n=%0d want clean pc 0", pq.size()); end
  endtask

  task automatic test_halt();
    lat = 1; instr_ready = 1; ovr_en = 1; ovr_addr = 32'h8; ovr_data = 32'hFFFF_FFFF; do_reset();
    repeat (16) @(negedge clk);
`ifdef IFU_HALT_DETECT_EN
    tests_run++; if (halted !== 1'b1 || imem_req !== 1'b0) begin failed++; $display("FAIL halt_set got h%b r%b want h1 r0", halted, imem_req); end
    tests_run++; if (rq.size() != 3) begin failed++; $display("FAIL halt_reqs got %0d want 3", rq.size()); end
    tests_run++; if (pq.size() != 2 || pq[0].pc !== 32'h0 || pq[1].pc !== 32'h4) begin failed++; $display("FAIL halt_pops got n=%0d want 0,4", pq.size()); end
    branch_taken = 1; branch_target = 32'h40;
    @(negedge clk); branch_taken = 0;
    tests_run++; if (halted !== 1'b0) begin failed++; $display("FAIL halt_clear got %b want 0", halted); end
    repeat (4) @(negedge clk);
    tests_run++; if (rq.size() < 4 || rq[3].addr !== 32'h40) begin failed++; $display("FAIL halt_refetch got n=%0d want addr 40", rq.size()); end
`else
    tests_run++; if (halted !== 1'b0) begin failed++; $display("FAIL halt_tied got %b want 0", halted); end
    tests_run++; if (pq.size() < 3 || pq[2].pc !== 32'h8 || pq[2].ins !== 32'hFFFF_FFFF) begin failed++; $display("FAIL halt_plain got n=%0d want pc 8 ins ffffffff", pq.size()); end
    tests_run++; if (rq.size() < 4) begin failed++; $display("FAIL halt_continue got %0d want >=4", rq.size()); end
`endif
    ovr_en = 0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_req, tgt;
    req_t r; pop_t p; int npops;
    npops = 0; lat_rand = 1; instr_ready = 1; do_reset();
    exp_pc = 32'h0; exp_req = 32'h0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      while (rq.size() > 0) begin
        r = rq.pop_front(); tests_run++;
        if (r.addr !== exp_req) begin failed++; $display("FAIL rand_req got %h want %h", r.addr, exp_req); end
        exp_req = r.addr + 32'd4;
      end
      while (pq.size() > 0) begin
        p = pq.pop_front(); tests_run++; npops++;
        if (p.pc !== exp_pc || p.ins !== mem_word(exp_pc)) begin failed++; $display("FAIL rand_pop got pc %h ins %h want pc %h ins %h", p.pc, p.ins, exp_pc, mem_word(exp_pc)); end
        exp_pc = p.pc + 32'd4;
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        tgt = $urandom & 32'h0000_FFFF;
        branch_taken = 1; branch_target = tgt;
        exp_pc = tgt & ~32'd3; exp_req = exp_pc;
      end else begin
        branch_taken = 0;
      end
    end
    branch_taken = 0; lat_rand = 0;
    tests_run++; if (npops < 30) begin failed++; $display("FAIL rand_progress got %0d want >=30", npops); end
    tests_run++; if (proto_err != 0) begin failed++; $display("FAIL rand_outstanding got %0d want 0", proto_err); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; branch_taken = 0; branch_target = '0; instr_ready = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch(3, "drop");
    test_branch(1, "coincident");
    test_fields();
    test_wrap();
    test_reset_midwait();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
